// File: rtl/spi_word_tx_pkg.sv
// Shared definitions for the SPI word transmitter: state codes, framing
// constants and the digit-to-ASCII byte mapping.
package spi_word_tx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        BYTE_GAP = 3'd3,
        CS_HOLD  = 3'd4,
        CS_IDLE  = 3'd5
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] ASCII_ZERO     = 8'h30;

    // Bytes holding a single decimal digit become the matching ASCII character.
    function automatic logic [31:0] ascii_map(input logic [31:0] w);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (w[8*i+4 +: 4] == 4'h0 && w[8*i +: 4] <= 4'd9) begin
                r[8*i +: 8] = w[8*i +: 8] | ASCII_ZERO;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_word_tx_clk_div.sv
// Half-period tick generator: pulses tick on the CLK_DIV-th enabled cycle,
// restarting from zero on clr or after each tick.
module spi_clk_div #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && !clr && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_word_tx.sv
// Serialises a 32-bit display word as four MSB-first SPI mode-0 bytes in one
// chip-select frame. Define SPI_TX_ASCII_EN to send digit bytes as ASCII.
module spi_word_tx
    import spi_word_tx_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        busy,
    output logic        done
);

    localparam int            GW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_TC    = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t        state_q, state_d;
    logic [31:0]   sreg_q, sreg_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          div_en, div_clr, tick;
    logic [31:0]   word_in;

`ifdef SPI_TX_ASCII_EN
    assign word_in = ascii_map(data_in);
`else
    assign word_in = data_in;
`endif

    // The divider is held at zero while idle or gapping so every timed phase starts fresh.
    assign div_en  = state_q inside {CS_SETUP, SHIFT, CS_HOLD, CS_IDLE};
    assign div_clr = (state_q == IDLE) || (state_q == BYTE_GAP);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (div_en),
        .clr  (div_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (data_valid && ready_q) begin
                    sreg_d  = word_in;
                    mosi_d  = word_in[31];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7 && byte_q == LAST_BYTE) begin
                            state_d = CS_HOLD;
                        end else begin
                            // Falling edge presents the next bit, including the next byte's MSB.
                            sreg_d = {sreg_q[30:0], 1'b0};
                            mosi_d = sreg_q[30];
                            bit_d  = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                byte_d = byte_q + 2'd1;
                                if (GAP_CYCLES > 0) begin
                                    gap_d   = '0;
                                    state_d = BYTE_GAP;
                                end
                            end
                        end
                    end
                end
            end
            BYTE_GAP: begin
                if (gap_q == GAP_TC) begin
                    state_d = SHIFT;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = CS_IDLE;
                end
            end
            CS_IDLE: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_ready = ready_q;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = mosi_q;
    assign spi_cs_n   = cs_n_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spi_word_tx.sv
// Bench for spi_word_tx: two instances (slow with gaps, fastest without)
// observed by an SPI slave monitor and checked against a word-level model.
`timescale 1ns/1ps
module tb_spi_word_tx;

    localparam int DIV_A = 2;
    localparam int GAP_A = 4;
    localparam int DIV_B = 1;
    localparam int GAP_B = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din [2];
    logic [1:0]  dval = 2'b00;
    logic [1:0]  drdy, sclk_o, mosi_o, csn, busy_o, done_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_word_tx #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_valid(dval[0]),
        .data_ready(drdy[0]), .spi_sclk(sclk_o[0]), .spi_mosi(mosi_o[0]),
        .spi_cs_n(csn[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    spi_word_tx #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_valid(dval[1]),
        .data_ready(drdy[1]), .spi_sclk(sclk_o[1]), .spi_mosi(mosi_o[1]),
        .spi_cs_n(csn[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    // Slave-side monitor, sampled on the falling clock edge.
    logic [1:0]  p_csn = 2'b11;
    logic [1:0]  p_sclk = 2'b00;
    logic [31:0] rx [2] = '{32'd0, 32'd0};
    logic [31:0] last_rx [2] = '{32'd0, 32'd0};
    int lo_cnt [2] = '{0, 0};
    int hi_run [2] = '{0, 0};
    int nrise [2] = '{0, 0};
    int mz [2] = '{0, 0};
    int frames [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int stray [2] = '{0, 0};
    int last_lo [2] = '{0, 0};
    int last_nrise [2] = '{0, 0};
    int last_mz [2] = '{0, 0};
    int last_hi [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done_o[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (p_csn[i] && !csn[i]) begin
                lo_cnt[i]  <= 1;
                rx[i]      <= '0;
                nrise[i]   <= 0;
                mz[i]      <= mosi_o[i] ? 0 : 1;
                last_hi[i] <= hi_run[i];
                hi_run[i]  <= 0;
            end else if (!csn[i]) begin
                lo_cnt[i] <= lo_cnt[i] + 1;
                if (!mosi_o[i]) mz[i] <= mz[i] + 1;
            end else begin
                hi_run[i] <= hi_run[i] + 1;
            end
            if (!p_csn[i] && csn[i]) begin
                last_rx[i]    <= rx[i];
                last_nrise[i] <= nrise[i];
                last_lo[i]    <= lo_cnt[i];
                last_mz[i]    <= mz[i];
                frames[i]     <= frames[i] + 1;
            end
            if (!p_sclk[i] && sclk_o[i]) begin
                if (!csn[i]) begin
                    rx[i]    <= {rx[i][30:0], mosi_o[i]};
                    nrise[i] <= nrise[i] + 1;
                end else begin
                    stray[i] <= stray[i] + 1;
                end
            end
        end
        p_csn  <= csn;
        p_sclk <= sclk_o;
    end

    // Word as the slave should see it: four bytes MSB-first, digits as ASCII when enabled.
    function automatic logic [31:0] model_word(input logic [31:0] w);
        logic [31:0] r;
        int b;
        r = 32'd0;
        for (int k = 0; k < 4; k++) begin
            b = int'((w >> (8 * (3 - k))) & 32'hFF);
`ifdef SPI_TX_ASCII_EN
            if (b < 10) b = b + 48;
`endif
            r = (r << 8) | 32'(b);
        end
        return r;
    endfunction

    function automatic int cs_low_exp(input int i);
        return (i == 0) ? (66 * DIV_A + 3 * GAP_A) : (66 * DIV_B + 3 * GAP_B);
    endfunction

    task automatic send(input int i, input logic [31:0] w, input string nm);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        din[i]  = w;
        dval[i] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (drdy[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s accept: data_ready never rose, required 1", nm);
        end else begin
            @(posedge clk);
            #1;
        end
        dval[i] = 1'b0;
    endtask

    task automatic wait_frame(input int i, input int f0, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (frames[i] != f0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s frame_end: chip select never released, required release", nm);
        end
    endtask

    task automatic check_frame(input int i, input logic [31:0] w, input string nm);
        total++;
        if (last_rx[i] !== model_word(w)) begin
            bad++;
            $display("FAIL %s data: got %08h required %08h", nm, last_rx[i], model_word(w));
        end
        total++;
        if (last_nrise[i] !== 32) begin
            bad++;
            $display("FAIL %s sclk_rises: got %0d required 32", nm, last_nrise[i]);
        end
        total++;
        if (last_lo[i] !== cs_low_exp(i)) begin
            bad++;
            $display("FAIL %s cs_low: got %0d required %0d", nm, last_lo[i], cs_low_exp(i));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({csn[i], sclk_o[i], mosi_o[i], drdy[i], busy_o[i], done_o[i]} !== 6'b100000) begin
                bad++;
                $display("FAIL reset_state dut%0d: got cs,sclk,mosi,rdy,busy,done=%b required 100000", i,
                         {csn[i], sclk_o[i], mosi_o[i], drdy[i], busy_o[i], done_o[i]});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (drdy !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready: got %b required 11", drdy);
        end
    endtask

    task automatic test_basic();
        int f0, d0, k;
        bit ok;
        f0 = frames[0];
        d0 = done_cnt[0];
        send(0, 32'h00010203, "basic");
        total++;
        if ({busy_o[0], drdy[0], csn[0]} !== 3'b100) begin
            bad++;
            $display("FAIL basic accept_state: got busy,rdy,cs=%b required 100", {busy_o[0], drdy[0], csn[0]});
        end
        ok = 1'b0;
        for (int j = 0; j < 2000; j++) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic done: pulse never seen, required one pulse");
        end
        k = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            k++;
            if (drdy[0] === 1'b1) break;
        end
        total++;
        if (k != DIV_A + 1) begin
            bad++;
            $display("FAIL basic ready_latency: got %0d required %0d", k, DIV_A + 1);
        end
        wait_frame(0, f0, "basic");
        check_frame(0, 32'h00010203, "basic");
        total++;
        if (done_cnt[0] - d0 != 1) begin
            bad++;
            $display("FAIL basic done_count: got %0d required 1", done_cnt[0] - d0);
        end
    endtask

    task automatic test_ascii();
        logic [31:0] e1, e2;
        int f0;
`ifdef SPI_TX_ASCII_EN
        e1 = 32'h30313239;
        e2 = 32'h3030300A;
`else
        e1 = 32'h00010209;
        e2 = 32'h0000000A;
`endif
        f0 = frames[0];
        send(0, 32'h00010209, "ascii1");
        wait_frame(0, f0, "ascii1");
        total++;
        if (last_rx[0] !== e1) begin
            bad++;
            $display("FAIL ascii1 data: got %08h required %08h", last_rx[0], e1);
        end
        f0 = frames[0];
        send(0, 32'h0000000A, "ascii2");
        wait_frame(0, f0, "ascii2");
        total++;
        if (last_rx[0] !== e2) begin
            bad++;
            $display("FAIL ascii2 data: got %08h required %08h", last_rx[0], e2);
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        bit ok;
        f0 = frames[0];
        @(negedge clk);
        din[0]  = 32'hA5A5A5A5;
        dval[0] = 1'b1;
        for (int s = 0; s < 2; s++) begin
            ok = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                if (drdy[0] === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL b2b accept%0d: data_ready never rose, required 1", s);
            end else begin
                @(posedge clk);
                #1;
            end
            din[0] = 32'h0F0F0F0F;
            @(negedge clk);
        end
        dval[0] = 1'b0;
        check_frame(0, 32'hA5A5A5A5, "b2b_first");
        wait_frame(0, f0 + 1, "b2b_second");
        check_frame(0, 32'h0F0F0F0F, "b2b_second");
        total++;
        if (last_hi[0] != DIV_A + 2) begin
            bad++;
            $display("FAIL b2b cs_high_between: got %0d required %0d", last_hi[0], DIV_A + 2);
        end
    endtask

    task automatic test_data_change();
        logic [31:0] w;
        int f0;
        bit ok;
        w  = $urandom;
        f0 = frames[0];
        send(0, w, "change");
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            din[0] = $urandom;
            if (frames[0] != f0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL change frame_end: chip select never released, required release");
        end
        check_frame(0, w, "change");
    endtask

    task automatic test_contiguous();
        int f0;
        f0 = frames[1];
        send(1, 32'hFFFFFFFF, "contig");
        wait_frame(1, f0, "contig");
        check_frame(1, 32'hFFFFFFFF, "contig");
        total++;
        if (last_mz[1] != 0) begin
            bad++;
            $display("FAIL contig mosi_low_cycles: got %0d required 0", last_mz[1]);
        end
    endtask

    task automatic test_reset_mid();
        int d0, f0;
        bit ok;
        d0 = done_cnt[0];
        send(0, $urandom, "rstmid");
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (nrise[0] >= 17) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid reach_byte2: never reached, required 17 rises");
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({csn[0], sclk_o[0], mosi_o[0], busy_o[0], drdy[0]} !== 5'b10000) begin
            bad++;
            $display("FAIL rstmid async_state: got cs,sclk,mosi,busy,rdy=%b required 10000",
                     {csn[0], sclk_o[0], mosi_o[0], busy_o[0], drdy[0]});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (drdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL rstmid ready_after_release: got %b required 1", drdy[0]);
        end
        repeat (2) @(negedge clk);
        total++;
        if (done_cnt[0] != d0) begin
            bad++;
            $display("FAIL rstmid done_count: got %0d required 0", done_cnt[0] - d0);
        end
        f0 = frames[0];
        send(0, 32'h12345678, "rstmid_next");
        wait_frame(0, f0, "rstmid_next");
        check_frame(0, 32'h12345678, "rstmid_next");
    endtask

    task automatic test_random();
        logic [31:0] w;
        int i, f0;
        for (int n = 0; n < 8; n++) begin
            i = n % 2;
            w = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'($urandom_range(0, 9));
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            f0 = frames[i];
            send(i, w, "random");
            wait_frame(i, f0, "random");
            check_frame(i, w, "random");
        end
        total++;
        if (stray[0] + stray[1] != 0) begin
            bad++;
            $display("FAIL random stray_sclk_edges: got %0d required 0", stray[0] + stray[1]);
        end
    endtask

    initial begin
        din[0] = 32'd0;
        din[1] = 32'd0;
        test_reset();
        test_basic();
        test_ascii();
        test_back_to_back();
        test_data_change();
        test_contiguous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
